// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the SCCB power-up configuration sequencer.
// The DELAY state exists only when SCCB_CFG_DELAY_EN is defined.
package sccb_cfg_pkg;

  localparam int unsigned ENTRY_W = 16;

  typedef logic [ENTRY_W-1:0] entry_t;

  localparam entry_t     TBL_END        = 16'hFFFF;
  localparam logic [7:0] TBL_DELAY_ADDR = 8'hFE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PWR_WAIT,
    S_FETCH,
    S_ISSUE,
    S_WAIT_BH,
    S_WAIT_BL,
    S_GAP,
`ifdef SCCB_CFG_DELAY_EN
    S_DELAY,
`endif
    S_DONE,
    S_ERR
  } state_t;

  function automatic entry_t mk_entry(input logic [7:0] addr, input logic [7:0] val);
    return {addr, val};
  endfunction

endpackage

// File: rtl/sccb_cfg_rom.sv
// Combinational 256x16 register table: index -> {address, value}; 16'hFFFF ends the table.
// TABLE_SEL 0 is the camera power-up table, 1 is a bring-up table with a settle-delay entry.
module sccb_cfg_rom
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned TABLE_SEL = 0
) (
  input  logic [7:0] index,
  output entry_t     entry
);

  always_comb begin
    entry = TBL_END;
    if (TABLE_SEL == 0) begin
      case (index)
        8'd0:    entry = mk_entry(8'h12, 8'h80);  // COM7: soft reset
        8'd1:    entry = mk_entry(8'h11, 8'h01);  // CLKRC: prescaler
        default: entry = TBL_END;
      endcase
    end else begin
      case (index)
        8'd0:    entry = mk_entry(8'h12, 8'h80);
        8'd1:    entry = mk_entry(TBL_DELAY_ADDR, 8'h03);
        8'd2:    entry = mk_entry(8'h11, 8'h01);
        default: entry = TBL_END;
      endcase
    end
  end

endmodule

// File: rtl/sccb_cfg_seq.sv
// Walks the register table and issues one SCCB_send write per entry via a toggle line.
// Optional macro SCCB_CFG_DELAY_EN: address 8'hFE entries become millisecond delays.
module sccb_cfg_seq
  import sccb_cfg_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned PWR_WAIT_MS  = 20,
  parameter int unsigned GAP_CYCLES   = 1000,
  parameter int unsigned BUSY_TIMEOUT = 4096,
  parameter int unsigned XFER_TIMEOUT = 262143,
  parameter int unsigned AUTO_START   = 1,
  parameter int unsigned TABLE_SEL    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       busy,
  output logic       send,
  output logic [7:0] address,
  output logic [7:0] value,
  output logic [7:0] index,
  output logic       cfg_done,
  output logic       cfg_err
);

  localparam logic [17:0] MS_LAST  = 18'(CLK_HZ / 1000 - 1);
  localparam logic [7:0]  PW_LAST  = 8'(PWR_WAIT_MS - 1);
  localparam logic [17:0] GAP_LAST = 18'(GAP_CYCLES - 1);
  localparam logic [17:0] BH_LAST  = 18'(BUSY_TIMEOUT - 1);
  localparam logic [17:0] BL_LAST  = 18'(XFER_TIMEOUT - 1);

  state_t      state, next_state;
  entry_t      entry;
  logic [17:0] cnt;
  logic [7:0]  ms_cnt;
  logic        auto_launched;
  logic        ms_tick, auto_go;
  logic        restart, latch, toggle, idx_inc, set_done, set_err;
  logic        ms_phase, idle_phase;

  sccb_cfg_rom #(.TABLE_SEL(TABLE_SEL)) u_rom (
    .index(index),
    .entry(entry)
  );

  assign ms_tick = (cnt == MS_LAST);
  assign auto_go = (AUTO_START != 0) && !auto_launched;

`ifdef SCCB_CFG_DELAY_EN
  logic [7:0] dly_last;
  // index is frozen during DELAY, so the table entry still holds the ms count
  assign dly_last = entry[7:0] - 8'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:     if (start || auto_go) next_state = S_PWR_WAIT;
      S_PWR_WAIT: if (ms_tick && ms_cnt == PW_LAST) next_state = S_FETCH;
      S_FETCH: begin
        if (entry == TBL_END) next_state = S_DONE;
`ifdef SCCB_CFG_DELAY_EN
        else if (entry[15:8] == TBL_DELAY_ADDR)
          next_state = (entry[7:0] == '0) ? S_GAP : S_DELAY;
`endif
        else next_state = S_ISSUE;
      end
      S_ISSUE:    next_state = S_WAIT_BH;
      S_WAIT_BH: begin
        if (busy)                next_state = S_WAIT_BL;
        else if (cnt == BH_LAST) next_state = S_ERR;
      end
      S_WAIT_BL: begin
        if (!busy)               next_state = S_GAP;
        else if (cnt == BL_LAST) next_state = S_ERR;
      end
      S_GAP:      if (cnt == GAP_LAST) next_state = S_FETCH;
`ifdef SCCB_CFG_DELAY_EN
      S_DELAY:    if (ms_tick && ms_cnt == dly_last) next_state = S_GAP;
`endif
      S_DONE,
      S_ERR:      if (start) next_state = S_PWR_WAIT;
      default:    next_state = S_IDLE;
    endcase
  end

  always_comb begin
    restart    = 1'b0;
    latch      = 1'b0;
    toggle     = 1'b0;
    idx_inc    = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
    ms_phase   = 1'b0;
    idle_phase = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        idle_phase = 1'b1;
        restart    = (next_state == S_PWR_WAIT);
      end
      S_PWR_WAIT: ms_phase = 1'b1;
      S_FETCH: begin
        latch    = (next_state == S_ISSUE);
        set_done = (next_state == S_DONE);
      end
      S_ISSUE: toggle = 1'b1;
      S_WAIT_BH, S_WAIT_BL: set_err = (next_state == S_ERR);
      S_GAP: idx_inc = (next_state == S_FETCH);
`ifdef SCCB_CFG_DELAY_EN
      S_DELAY: ms_phase = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      send          <= 1'b0;
      address       <= '0;
      value         <= '0;
      index         <= '0;
      cfg_done      <= 1'b0;
      cfg_err       <= 1'b0;
      cnt           <= '0;
      ms_cnt        <= '0;
      auto_launched <= 1'b0;
    end else begin
      if (restart) begin
        cfg_done      <= 1'b0;
        cfg_err       <= 1'b0;
        index         <= '0;
        auto_launched <= 1'b1;
      end
      if (latch) begin
        address <= entry[15:8];
        value   <= entry[7:0];
      end
      if (toggle)   send     <= ~send;
      if (idx_inc)  index    <= index + 8'd1;
      if (set_done) cfg_done <= 1'b1;
      if (set_err)  cfg_err  <= 1'b1;
      // shared counter: per-state cycle count, or ms prescaler while waiting
      if (next_state != state || idle_phase) begin
        cnt    <= '0;
        ms_cnt <= '0;
      end else if (ms_phase && ms_tick) begin
        cnt    <= '0;
        ms_cnt <= ms_cnt + 8'd1;
      end else begin
        cnt <= cnt + 18'd1;
      end
    end
  end

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// Scoreboard bench for sccb_cfg_seq: expected writes are queued, a monitor checks each send edge.
// A second instance carries the table with an 8'hFE entry; only the selected instance is out of reset.
`timescale 1ns/1ps
module tb_sccb_cfg_seq;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned PW_MS  = 2;
  localparam int unsigned GAP    = 10;
  localparam int unsigned BH_TO  = 4096;
  localparam int unsigned BL_TO  = 300;

  typedef struct {
    logic [7:0] a;
    logic [7:0] v;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, sel, bm_busy;
  logic       rst0, rst1, busy0, busy1;
  logic       send0, send1, done0, done1, err0, err1;
  logic [7:0] addr0, addr1, val0, val1, idx0, idx1;
  logic       m_send, m_done, m_err;
  logic [7:0] m_addr, m_val, m_idx;

  assign rst0   = rst_n & ~sel;
  assign rst1   = rst_n & sel;
  assign busy0  = sel ? 1'b0 : bm_busy;
  assign busy1  = sel ? bm_busy : 1'b0;
  assign m_send = sel ? send1 : send0;
  assign m_addr = sel ? addr1 : addr0;
  assign m_val  = sel ? val1  : val0;
  assign m_idx  = sel ? idx1  : idx0;
  assign m_done = sel ? done1 : done0;
  assign m_err  = sel ? err1  : err0;

  sccb_cfg_seq #(
    .CLK_HZ(CLK_HZ), .PWR_WAIT_MS(PW_MS), .GAP_CYCLES(GAP),
    .BUSY_TIMEOUT(BH_TO), .XFER_TIMEOUT(BL_TO), .AUTO_START(1), .TABLE_SEL(0)
  ) dut (
    .clk(clk), .rst_n(rst0), .start(start), .busy(busy0), .send(send0),
    .address(addr0), .value(val0), .index(idx0), .cfg_done(done0), .cfg_err(err0)
  );

  sccb_cfg_seq #(
    .CLK_HZ(CLK_HZ), .PWR_WAIT_MS(PW_MS), .GAP_CYCLES(GAP),
    .BUSY_TIMEOUT(BH_TO), .XFER_TIMEOUT(BL_TO), .AUTO_START(1), .TABLE_SEL(1)
  ) dut_d (
    .clk(clk), .rst_n(rst1), .start(start), .busy(busy1), .send(send1),
    .address(addr1), .value(val1), .index(idx1), .cfg_done(done1), .cfg_err(err1)
  );

  int   checks = 0;
  int   errors = 0;
  int   pe = 0;
  int   rel = 0;
  int   edges = 0;
  int   last_edge_cyc = 0;
  int   mode = 0;   // busy model: 0 normal, 1 stuck low, 2 stuck high
  exp_t exp_q[$];

  always @(posedge clk) pe <= pe + 1;

  function automatic int cur_cyc();
    return pe - rel - 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] v, input int cyc);
    exp_t e;
    e.a = a; e.v = v; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    edges = 0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    rel   = pe;
  endtask

  task automatic wait_flag(input bit want_err, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (want_err ? m_err : m_done) begin
        at = cur_cyc();
        break;
      end
    end
    chk(want_err ? "err_within_bound" : "done_within_bound", 32'(at >= 0), 32'd1);
  endtask

  // SCCB_send stand-in: busy rises the cycle after a send edge and holds 50 cycles
  initial begin : busy_model
    logic bs_prev;
    int   hcnt;
    bm_busy = 1'b0; bs_prev = 1'b0; hcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bm_busy = 1'b0; bs_prev = m_send; hcnt = 0;
      end else if (m_send != bs_prev) begin
        bs_prev = m_send;
        case (mode)
          0:       begin bm_busy = 1'b1; hcnt = 50; end
          1:       bm_busy = 1'b0;
          default: bm_busy = 1'b1;
        endcase
      end else if (mode == 0) begin
        if (hcnt > 0) hcnt--;
        if (hcnt == 0) bm_busy = 1'b0;
      end else if (mode == 1) begin
        bm_busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    logic        prev, bad;
    logic [15:0] cap;
    int          hold;
    exp_t        e;
    prev = 1'b0; bad = 1'b0; cap = '0; hold = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev = m_send;
        hold = 0;
      end else if (m_send != prev) begin
        prev = m_send;
        edges++;
        last_edge_cyc = cur_cyc();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_edge: got %02h/%02h at cycle %0d, required no edge",
                   m_addr, m_val, last_edge_cyc);
        end else begin
          e = exp_q.pop_front();
          chk("edge_address", 32'(m_addr), 32'(e.a));
          chk("edge_value", 32'(m_val), 32'(e.v));
          chk("edge_cycle", 32'(last_edge_cyc), 32'(e.cyc));
        end
        cap  = {m_addr, m_val};
        hold = 1;
        bad  = 1'b0;
      end else if (hold != 0) begin
        if ({m_addr, m_val} != cap) bad = 1'b1;
        if (hold == 1 && bm_busy) hold = 2;
        else if (hold == 2 && !bm_busy) begin
          chk("addr_value_stable", 32'(bad), 32'd0);
          hold = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int at, s;
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({send0, addr0, val0, idx0, done0, err0}), 32'd0);

    // Normal run; a start pulse mid-transfer must be ignored
    push(8'h12, 8'h80, 2002);
    push(8'h11, 8'h01, 2065);
    release_rst();
    repeat (2020) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_flag(1'b0, 6000, at);
    chk("t1_done_cycle", 32'(at), 32'd2127);
    chk("t1_err_low", 32'(m_err), 32'd0);
    chk("t1_index", 32'(m_idx), 32'd2);
    chk("t1_edges", 32'(edges), 32'd2);
    chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // busy never rises
    do_reset();
    mode = 1;
    push(8'h12, 8'h80, 2002);
    release_rst();
    wait_flag(1'b1, 8000, at);
    chk("t2_err_cycle", 32'(at), 32'd6098);
    chk("t2_done_low", 32'(m_done), 32'd0);
    chk("t2_index", 32'(m_idx), 32'd0);
    repeat (100) @(negedge clk);
    chk("t2_edges", 32'(edges), 32'd1);
    chk("t2_send_held", 32'(m_send), 32'd1);

    // busy stuck high, then restart with normal busy
    do_reset();
    mode = 2;
    push(8'h12, 8'h80, 2002);
    release_rst();
    wait_flag(1'b1, 4000, at);
    chk("t3_err_cycle", 32'(at), 32'(2002 + 1 + BL_TO));
    chk("t3_index", 32'(m_idx), 32'd0);
    mode = 0;
    repeat (5) @(negedge clk);
    s = cur_cyc() + 1;
    push(8'h12, 8'h80, s + 2002);
    push(8'h11, 8'h01, s + 2065);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_err_cleared", 32'(m_err), 32'd0);
    wait_flag(1'b0, 6000, at);
    chk("t3_done_cycle", 32'(at), 32'(s + 2127));
    chk("t3_edges", 32'(edges), 32'd3);

    // asynchronous reset while busy is high
    do_reset();
    mode = 0;
    push(8'h12, 8'h80, 2002);
    release_rst();
    repeat (2020) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t4_async_reset", 32'({send0, addr0, val0, idx0, done0, err0}), 32'd0);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    push(8'h12, 8'h80, 2002);
    push(8'h11, 8'h01, 2065);
    release_rst();
    wait_flag(1'b0, 6000, at);
    chk("t4_done_cycle", 32'(at), 32'd2127);
    chk("t4_edges", 32'(edges), 32'd3);

    // table with an 8'hFE entry on the second instance
    do_reset();
    sel = 1'b1;
    push(8'h12, 8'h80, 2002);
`ifdef SCCB_CFG_DELAY_EN
    push(8'h11, 8'h01, 5076);
`else
    push(8'hFE, 8'h03, 2065);
    push(8'h11, 8'h01, 2128);
`endif
    release_rst();
    wait_flag(1'b0, 9000, at);
`ifdef SCCB_CFG_DELAY_EN
    chk("t5_done_cycle", 32'(at), 32'd5138);
    chk("t5_edges", 32'(edges), 32'd2);
`else
    chk("t5_done_cycle", 32'(at), 32'd2190);
    chk("t5_edges", 32'(edges), 32'd3);
`endif
    chk("t5_index", 32'(m_idx), 32'd3);
    chk("t5_err_low", 32'(m_err), 32'd0);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
